// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by uart_rx, uart_tx and baud_generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;
  localparam int UART_DATA_BITS_DEFAULT  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, byte and strobes out.
interface uart_rx_if import uart_pkg::*; #(
  parameter int DATA_BITS = UART_DATA_BITS_DEFAULT
);

  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output tick, rx,
    input  data, valid, frame_error, busy
  );

  modport slave (
    input  tick, rx,
    output data, valid, frame_error, busy
  );

endinterface

// File: rtl/baud_generator.sv
// Free-running divider producing a 1-clk enable pulse every DIV clocks.
module baud_generator #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic enable
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      enable <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      enable <= 1'b1;
    end else begin
      cnt    <= cnt + DW'(1);
      enable <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_synchronizer.sv
// Generic 2-FF synchroniser for asynchronous pins; RESET_VAL sets the value
// both stages hold in reset so an idle line does not look like an edge.
module bit_synchronizer #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 receiver: qualifies the start bit at mid-bit, samples each
// data bit at its centre and checks the stop bit, strobing valid or frame_error.
module uart_rx import uart_pkg::*; #(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 rx_s;

  bit_synchronizer #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
          // A start bit that is no longer low at mid-bit was a glitch.
          START: begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == CNT_FULL) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              cnt     <= '0;
              bit_idx <= bit_idx + BW'(1);
              if (bit_idx == BIT_LAST) state <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == CNT_FULL) begin
              if (rx_s) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
              cnt    <= '0;
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx fed by a real baud_generator (DIV=8, 16x oversample).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS  = 16;
  localparam int DIV = 8;
  localparam int BIT = OS * DIV;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  baud_generator #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.tick)
  );

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         tick_cnt  = 0;
  int         valid_cnt = 0;
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  logic [7:0] data_log [16];
  int         tick_log [16];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tick) tick_cnt++;
      if (bus.valid) begin
        data_log[valid_cnt % 16] = bus.data;
        tick_log[valid_cnt % 16] = tick_cnt;
        valid_cnt++;
      end
      if (bus.frame_error) fe_cnt++;
      if (bus.valid && bus.frame_error) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
    bus.rx = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0, f0, sp;

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data",  32'(bus.data), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_ferr",  32'(bus.frame_error), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    rst = 1'b0;
    idle(20);

    // single byte
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b1, BIT);
    idle(2 * BIT);
    chk("a5_vcnt", 32'(valid_cnt - v0), 32'd1);
    chk("a5_data", 32'(bus.data), 32'hA5);
    chk("a5_ferr", 32'(fe_cnt - f0), 32'd0);
    chk("a5_busy", 32'(bus.busy), 32'd0);

    // back-to-back, no idle gap
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    idle(2 * BIT);
    chk("b2b_vcnt",  32'(valid_cnt - v0), 32'd2);
    chk("b2b_data0", 32'(data_log[v0 % 16]), 32'h00);
    chk("b2b_data1", 32'(data_log[(v0 + 1) % 16]), 32'hFF);
    sp = tick_log[(v0 + 1) % 16] - tick_log[v0 % 16];
    chk("b2b_space", 32'(sp), 32'(10 * OS));
    chk("b2b_ferr",  32'(fe_cnt - f0), 32'd0);

    // 3-tick low glitch
    v0 = valid_cnt; f0 = fe_cnt;
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    chk("gl_busy_hi", 32'(bus.busy), 32'd1);
    repeat (3 * DIV - 16) @(negedge clk);
    bus.rx = 1'b1;
    repeat (96 - 3 * DIV) @(negedge clk);
    chk("gl_busy_lo", 32'(bus.busy), 32'd0);
    idle(2 * BIT);
    chk("gl_vcnt", 32'(valid_cnt - v0), 32'd0);
    chk("gl_ferr", 32'(fe_cnt - f0), 32'd0);

    // bad stop bit
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h5A, 1'b0, BIT);
    idle(2 * BIT);
    chk("fe_ferr", 32'(fe_cnt - f0), 32'd1);
    chk("fe_vcnt", 32'(valid_cnt - v0), 32'd0);
    chk("fe_data", 32'(bus.data), 32'hFF);

    // reset mid-frame after 4 data bits of 0x3C
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(((8'h3C >> i) & 8'h1) != 0, BIT);
    repeat (BIT / 2) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_data",  32'(bus.data), 32'h0);
    chk("mr_busy",  32'(bus.busy), 32'h0);
    chk("mr_valid", 32'(bus.valid), 32'h0);
    chk("mr_ferr",  32'(bus.frame_error), 32'h0);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(BIT);
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b1, BIT);
    idle(2 * BIT);
    chk("ar_vcnt", 32'(valid_cnt - v0), 32'd1);
    chk("ar_data", 32'(bus.data), 32'h3C);

    // baud mismatch: 3 % slow then 3 % fast
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h81, 1'b1, 132);
    idle(2 * BIT);
    chk("slow_vcnt", 32'(valid_cnt - v0), 32'd1);
    chk("slow_data", 32'(bus.data), 32'h81);
    chk("slow_ferr", 32'(fe_cnt - f0), 32'd0);
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h81, 1'b1, 124);
    idle(2 * BIT);
    chk("fast_vcnt", 32'(valid_cnt - v0), 32'd1);
    chk("fast_data", 32'(bus.data), 32'h81);
    chk("fast_ferr", 32'(fe_cnt - f0), 32'd0);

    chk("excl", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that consumes the 1-cycle `enable` pulse from `baud_generator` (OVERSAMPLE × BAUD rate) and deserialises an 8N1 serial line into parallel bytes. It sits directly downstream of `baud_generator` in the serial path. It synchronises the asynchronous `rx` pin, qualifies the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit. It presents each byte with a one-cycle `valid` strobe, or a one-cycle `frame_error` strobe if the stop bit is bad.

## Interface
- `OVERSAMPLE`, 16, ticks per bit; must be even and ≥ 4
- `DATA_BITS`, 8, data bits per frame, LSB first
- `clk`  input  1  system clock
- `rst`  input  1  asynchronous, active-high reset
- `tick`  input  1  oversample strobe from `baud_generator.enable`; 1 clk wide
- `rx`  input  1  asynchronous serial line; idle high
- `data`  output  DATA_BITS  last good byte; reset 0
- `valid`  output  1  1-clk pulse when `data` is updated; reset 0
- `frame_error`  output  1  1-clk pulse on bad stop bit; reset 0
- `busy`  output  1  high whenever state ≠ IDLE; reset 0

## Operation
- `rx` passes through a 2-FF synchroniser (`rx_s`). Both flops reset to 1.
- State machine: IDLE, START, DATA, STOP. State and counters advance only on cycles where `tick`=1; otherwise everything holds.
- `cnt` is a tick counter, width $clog2(OVERSAMPLE). `bit_idx` has width $clog2(DATA_BITS+1).
- IDLE, on a tick with `rx_s`=0: go to START with `cnt`=0.
- START, on each tick, `cnt`++. When `cnt`==OVERSAMPLE/2−1 (mid-bit):
  - if `rx_s`=0: go to DATA with `cnt`=0, `bit_idx`=0;
  - else: treat as a glitch and return to IDLE with no strobe.
- DATA, on each tick, `cnt`++. When `cnt`==OVERSAMPLE−1:
  - shift `rx_s` into the MSB of the shift register (right shift, so the first bit ends in the LSB);
  - set `cnt`=0 and increment `bit_idx`;
  - when `bit_idx` reaches DATA_BITS, go to STOP.
- STOP, on each tick, `cnt`++. When `cnt`==OVERSAMPLE−1:
  - if `rx_s`=1: load `data` from the shift register and pulse `valid`;
  - else: pulse `frame_error` and leave `data` unchanged;
  - return to IDLE in both cases.
- After IDLE is re-entered, a low `rx_s` on the next tick starts a new frame. Back-to-back frames need no idle gap.
- A break (line held low) produces `frame_error`, then restarts START on the next tick. This repeats once per frame time for as long as the line stays low.
- `rst` asserted at any time, including mid-frame, immediately forces:
  - IDLE state;
  - `cnt`, `bit_idx` and the shift register to 0;
  - all outputs to their reset values.

## Timing
- `rx` to `rx_s` latency: 2 clk.
- Sampling points fall at OVERSAMPLE/2 ticks after the detected start edge, then every OVERSAMPLE ticks.
  - Edge-detection uncertainty is 1 tick (≤ 1/OVERSAMPLE of a bit).
  - Tolerated baud mismatch: about ±4 % at OVERSAMPLE=16.
- `valid` and `frame_error` are registered. Each goes high on the clk edge following the tick that samples the stop bit and lasts exactly 1 clk.
- `valid` and `frame_error` are mutually exclusive and never high in consecutive cycles within one frame.
- `data` changes only in the same cycle `valid` rises and is stable until the next `valid`.
- `busy` rises 1 clk after the tick that detects start and falls with the `valid`/`frame_error` cycle.
- Frame length, start-detect tick to strobe: OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks, plus 1 clk.

## Structure
- Shared package `uart_pkg` holds:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP);
  - `UART_OVERSAMPLE_DEFAULT`=16 and `UART_DATA_BITS_DEFAULT`=8, so `uart_tx` and `baud_generator` instances use the same values.
- One sub-module, `bit_synchronizer`: generic 2-FF synchroniser with a reset-value parameter (set to 1 here). It will be reused for other pin inputs.
- Everything else stays flat in `uart_rx`.

## Test plan
Bench drives `tick` from a real `baud_generator` with DIV=8, and drives `rx` with a task that toggles every 8·OVERSAMPLE clk.
- Send 0xA5 → exactly one `valid` pulse, `data`=0xA5, `frame_error` never high, `busy` low afterwards.
- Send 0x00 then 0xFF back-to-back with no idle gap → two `valid` pulses, `data`=0x00 then 0xFF, spacing 10·OVERSAMPLE ticks.
- Low glitch on `rx` lasting 3 ticks → no `valid`, no `frame_error`, `busy` returns to 0 by OVERSAMPLE/2 ticks.
- Send 0x5A with stop bit forced low → one `frame_error` pulse, no `valid`, `data` keeps its previous value (0xFF).
- Assert `rst` after 4 data bits of 0x3C → all outputs 0 within the same cycle. After release, a fresh 0x3C yields `valid` with `data`=0x3C.
- Send 0x81 with the bit period 3 % slow, then 3 % fast → `data`=0x81 both times, no `frame_error`.
